// File: rtl/complex_div_pkg.sv
// complex_div_pkg: state encoding, iteration count and saturation bounds
// shared by the complex divider datapath.
`default_nettype none

package complex_div_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_PREP = 3'd2,
    S_DIV  = 3'd3,
    S_SAT  = 3'd4
  } state_t;

  // One quotient bit per step: full-width magnitude plus the fractional shift.
  function automatic int calc_ndiv(input int size_data, input int frac_bits);
    return 2 * size_data + 1 + frac_bits;
  endfunction

  function automatic longint sat_max(input int size_data);
    return (longint'(1) << (size_data - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int size_data);
    return -(longint'(1) << (size_data - 1));
  endfunction

endpackage

`default_nettype wire

// File: rtl/complex_div_div_restoring_step.sv
// div_restoring_step: one combinational restoring-division step
// (remainder, next dividend bit, divisor -> next remainder, quotient bit).
`default_nettype none

module div_restoring_step #(
  parameter int WIDTH = 33
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  assign shifted  = {rem, bit_in};
  assign diff     = shifted - {1'b0, divisor};
  assign q_bit    = ~diff[WIDTH];
  assign rem_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

`default_nettype wire

// File: rtl/complex_div.sv
// complex_div: iterative complex divider (a+jb)/(c+jd), fixed latency,
// shared restoring-division loop for I and Q.
`default_nettype none

module complex_div
  import complex_div_pkg::*;
#(
  parameter int SIZE_DATA = 16,
  parameter int FRAC_BITS = 14
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [SIZE_DATA-1:0] in_data1_i,
  input  logic [SIZE_DATA-1:0] in_data1_q,
  input  logic [SIZE_DATA-1:0] in_data2_i,
  input  logic [SIZE_DATA-1:0] in_data2_q,
  output logic [SIZE_DATA-1:0] out_data_i,
  output logic [SIZE_DATA-1:0] out_data_q,
  output logic                 outputValid,
  output logic                 busy,
  output logic                 div_by_zero
);

  localparam int W    = 2 * SIZE_DATA + 1;
  localparam int NDIV = calc_ndiv(SIZE_DATA, FRAC_BITS);
  localparam int CW   = $clog2(NDIV + 1);
  localparam logic [NDIV-1:0] POS_LIM = NDIV'(sat_max(SIZE_DATA));
  localparam logic [NDIV-1:0] NEG_LIM = NDIV'(-sat_min(SIZE_DATA));

  state_t                     state;
  logic signed [SIZE_DATA-1:0] a_r, b_r, c_r, d_r;
  logic signed [W-1:0]        num_i, num_q;
  logic        [W-1:0]        den;
  logic        [W-1:0]        rem_i, rem_q;
  logic        [NDIV-1:0]     dvd_i, dvd_q;
  logic                       neg_i, neg_q, zero;
  logic        [CW-1:0]       cnt;

  logic signed [W-1:0] ax, bx, cx, dx;
  logic        [W-1:0] mag_i, mag_q, nrem_i, nrem_q;
  logic                qb_i, qb_q;

  assign ax = W'(a_r);
  assign bx = W'(b_r);
  assign cx = W'(c_r);
  assign dx = W'(d_r);

  assign mag_i = num_i[W-1] ? -num_i : num_i;
  assign mag_q = num_q[W-1] ? -num_q : num_q;

  div_restoring_step #(.WIDTH(W)) u_step_i (
    .rem      (rem_i),
    .bit_in   (dvd_i[NDIV-1]),
    .divisor  (den),
    .rem_next (nrem_i),
    .q_bit    (qb_i)
  );

  div_restoring_step #(.WIDTH(W)) u_step_q (
    .rem      (rem_q),
    .bit_in   (dvd_q[NDIV-1]),
    .divisor  (den),
    .rem_next (nrem_q),
    .q_bit    (qb_q)
  );

  // Negative magnitudes up to 2^(SIZE_DATA-1) map exactly onto the most-negative code.
  function automatic logic [SIZE_DATA-1:0] saturate(input logic neg, input logic [NDIV-1:0] mag);
    if (!neg)
      return (mag > POS_LIM) ? POS_LIM[SIZE_DATA-1:0] : mag[SIZE_DATA-1:0];
    else
      return (mag > NEG_LIM) ? NEG_LIM[SIZE_DATA-1:0] : -mag[SIZE_DATA-1:0];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      a_r         <= '0;
      b_r         <= '0;
      c_r         <= '0;
      d_r         <= '0;
      num_i       <= '0;
      num_q       <= '0;
      den         <= '0;
      rem_i       <= '0;
      rem_q       <= '0;
      dvd_i       <= '0;
      dvd_q       <= '0;
      neg_i       <= 1'b0;
      neg_q       <= 1'b0;
      zero        <= 1'b0;
      cnt         <= '0;
      out_data_i  <= '0;
      out_data_q  <= '0;
      outputValid <= 1'b0;
      busy        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      outputValid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (en) begin
            a_r   <= in_data1_i;
            b_r   <= in_data1_q;
            c_r   <= in_data2_i;
            d_r   <= in_data2_q;
            busy  <= 1'b1;
            state <= S_MUL;
          end
        end
        S_MUL: begin
          num_i <= ax * cx + bx * dx;
          num_q <= bx * cx - ax * dx;
          den   <= cx * cx + dx * dx;
          state <= S_PREP;
        end
        S_PREP: begin
          dvd_i <= {mag_i, {FRAC_BITS{1'b0}}};
          dvd_q <= {mag_q, {FRAC_BITS{1'b0}}};
          rem_i <= '0;
          rem_q <= '0;
          neg_i <= num_i[W-1];
          neg_q <= num_q[W-1];
          zero  <= (den == '0);
          cnt   <= CW'(NDIV);
          state <= S_DIV;
        end
        S_DIV: begin
          // Dividend bits shift out the top while quotient bits fill in at the bottom.
          rem_i <= nrem_i;
          rem_q <= nrem_q;
          dvd_i <= {dvd_i[NDIV-2:0], qb_i};
          dvd_q <= {dvd_q[NDIV-2:0], qb_q};
          cnt   <= cnt - 1'b1;
          if (cnt == CW'(1))
            state <= S_SAT;
        end
        S_SAT: begin
          out_data_i  <= zero ? '0 : saturate(neg_i, dvd_i);
          out_data_q  <= zero ? '0 : saturate(neg_q, dvd_q);
          div_by_zero <= zero;
          outputValid <= 1'b1;
          busy        <= 1'b0;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_complex_div.sv
// tb_complex_div: scoreboard bench for complex_div against an integer
// reference model of the complex quotient.
`default_nettype none

module tb_complex_div;

  localparam int SD  = 16;
  localparam int FB  = 14;
  localparam int LAT = 50;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 en = 1'b0;
  logic [SD-1:0]        in_data1_i = '0, in_data1_q = '0, in_data2_i = '0, in_data2_q = '0;
  logic [SD-1:0]        out_data_i, out_data_q;
  logic                 outputValid, busy, div_by_zero;

  typedef struct {
    int i;
    int q;
    int dz;
    int acc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  complex_div #(.SIZE_DATA(SD), .FRAC_BITS(FB)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .in_data1_i  (in_data1_i),
    .in_data1_q  (in_data1_q),
    .in_data2_i  (in_data2_i),
    .in_data2_q  (in_data2_q),
    .out_data_i  (out_data_i),
    .out_data_q  (out_data_q),
    .outputValid (outputValid),
    .busy        (busy),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic longint sat(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic exp_t model(input int a, input int b, input int c, input int d);
    exp_t   e;
    longint ni, nq, dn, qi, qq;
    ni = longint'(a) * c + longint'(b) * d;
    nq = longint'(b) * c - longint'(a) * d;
    dn = longint'(c) * c + longint'(d) * d;
    e.acc = 0;
    if (dn == 0) begin
      e.i = 0; e.q = 0; e.dz = 1;
    end else begin
      qi = ((ni < 0 ? -ni : ni) << FB) / dn;
      qq = ((nq < 0 ? -nq : nq) << FB) / dn;
      e.i  = int'(sat(ni < 0 ? -qi : qi));
      e.q  = int'(sat(nq < 0 ? -qq : qq));
      e.dz = 0;
    end
    return e;
  endfunction

  task automatic set_inputs(input int a, input int b, input int c, input int d);
    in_data1_i = SD'(a);
    in_data1_q = SD'(b);
    in_data2_i = SD'(c);
    in_data2_q = SD'(d);
  endtask

  task automatic push_exp(input int a, input int b, input int c, input int d, input int acc);
    exp_t e;
    e = model(a, b, c, d);
    e.acc = acc;
    sb.push_back(e);
  endtask

  task automatic start_op(input int a, input int b, input int c, input int d);
    @(negedge clk);
    set_inputs(a, b, c, d);
    en = 1'b1;
    push_exp(a, b, c, d, cyc + 1);
    @(negedge clk);
    en = 1'b0;
    check("busy_after_en", busy, 1);
  endtask

  task automatic wait_done();
    int t = 0;
    while (sb.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      check("timeout_pending", sb.size(), 0);
      sb.delete();
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && outputValid) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_i", $signed(out_data_i), e.i);
        check("out_q", $signed(out_data_q), e.q);
        check("div_by_zero", div_by_zero, e.dz);
        check("latency", cyc - e.acc, LAT);
        check("busy_at_valid", busy, 0);
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_out_i", out_data_i, 0);
    check("rst_out_q", out_data_q, 0);
    check("rst_valid", outputValid, 0);
    check("rst_busy", busy, 0);
    check("rst_dz", div_by_zero, 0);
    rst_n = 1'b1;

    start_op(16384, 0, 16384, 0);     wait_done();
    start_op(16384, 0, 0, 16384);     wait_done();
    start_op(3, 4, 5, 10);            wait_done();
    start_op(32767, -32768, 1, 0);    wait_done();
    start_op(32767, -32768, 0, 0);    wait_done();
    start_op(-32768, -32768, -32768, -32768); wait_done();
    start_op(0, 0, 123, -456);        wait_done();
    start_op(-100, 7, 3, -2);         wait_done();
    for (int n = 0; n < 4; n++) begin
      start_op(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768,
               int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768);
      wait_done();
    end

    // en held high across three operations: accepts land 51 cycles apart.
    @(negedge clk);
    set_inputs(1000, -2000, 300, 400);
    en = 1'b1;
    push_exp(1000, -2000, 300, 400, cyc + 1);
    @(negedge clk);
    set_inputs(-5, 9, 2, 0);
    push_exp(-5, 9, 2, 0, cyc + 51);
    repeat (51) @(negedge clk);
    set_inputs(7, 7, 0, 0);
    push_exp(7, 7, 0, 0, cyc + 51);
    repeat (51) @(negedge clk);
    en = 1'b0;
    wait_done();

    // Strobes while busy must be ignored.
    start_op(12345, -6789, 111, 222);
    set_inputs(1, 1, 1, 1);
    repeat (9) @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    repeat (39) @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    wait_done();
    repeat (60) @(negedge clk);

    // Reset in the middle of an operation aborts it.
    start_op(500, 600, 700, 800);
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("midrst_out_i", out_data_i, 0);
    check("midrst_out_q", out_data_q, 0);
    check("midrst_busy", busy, 0);
    check("midrst_valid", outputValid, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    start_op(3, 4, 5, 10);
    wait_done();

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/complex_div.md
Name: complex_div

Overview:
- Iterative complex divider: computes (in_data1_i + j*in_data1_q) / (in_data2_i + j*in_data2_q).
- Used by the OFDM receive path for channel estimation (H = Y/X on pilots) and zero-forcing equalisation.
- It is the inverse of the complex multiplier.
- Single restoring-division datapath, shared I/Q iteration, fixed latency, same en/outputValid handshake as the rest of the FFT/OFDM blocks.

Parameters:
- SIZE_DATA, 16, width of each signed input and output component.
- FRAC_BITS, 14, number of fractional bits in the output quotient (Q(SIZE_DATA-1-FRAC_BITS).FRAC_BITS).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  start strobe; sampled only when idle.
- in_data1_i  input  SIZE_DATA  numerator real part (a), signed.
- in_data1_q  input  SIZE_DATA  numerator imaginary part (b), signed.
- in_data2_i  input  SIZE_DATA  denominator real part (c), signed.
- in_data2_q  input  SIZE_DATA  denominator imaginary part (d), signed.
- out_data_i  output  SIZE_DATA  quotient real part, signed, FRAC_BITS fractional bits.
- out_data_q  output  SIZE_DATA  quotient imaginary part, signed.
- outputValid  output  1  one-cycle pulse when out_data_* update.
- busy  output  1  high from the cycle after an accepted en until outputValid.
- div_by_zero  output  1  valid with outputValid; high when c = d = 0.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE.
  - out_data_i, out_data_q = 0.
  - outputValid, busy, div_by_zero = 0.
  - Iteration counter and internal registers = 0.
  - Reset mid-operation aborts the computation; no outputValid is produced.
- Maths:
  - num_i = a*c + b*d; num_q = b*c - a*d; den = c^2 + d^2.
  - All products and sums are full width, 2*SIZE_DATA+1 bits, no overflow.
  - Quotient = trunc_toward_zero(num * 2^FRAC_BITS / den), computed on magnitudes; the sign is applied afterwards.
  - Saturate to [-2^(SIZE_DATA-1), 2^(SIZE_DATA-1)-1].
- States:
  - IDLE: en=1 latches all four inputs, busy<=1, go to MUL. Inputs are don't-care afterwards.
  - MUL (1 cycle): register num_i, num_q, den.
  - PREP (1 cycle):
    - Register |num_i|, |num_q| shifted left by FRAC_BITS; register sign bits and den.
    - Set internal zero flag if den==0.
    - Load counter with NDIV = 2*SIZE_DATA+1+FRAC_BITS.
  - DIV (NDIV cycles): one restoring-division step per cycle, I and Q in parallel against the shared den; counter decrements; leave at 0.
  - SAT (1 cycle):
    - Apply signs and saturate; register out_data_i/q.
    - div_by_zero <= zero flag; on zero: out_data_i/q = 0.
    - outputValid <= 1 for exactly this one cycle; busy <= 0; return to IDLE.
- Latency:
  - en sampled at edge k -> outputValid high after edge k+L, where L = NDIV+3 (50 for defaults).
  - L is fixed for every operand, including divide-by-zero.
- Handshake:
  - en while busy is ignored; no queueing.
  - en may be asserted in the cycle right after outputValid, giving throughput of one result per L+1 cycles.
- Between results, out_data_* and div_by_zero hold their last values.
- Corner cases:
  - Most-negative inputs (-2^(SIZE_DATA-1)) must be handled exactly; the magnitude path is one bit wider.
  - num = 0 with den != 0 gives exactly 0, not -0 artefacts.

Decomposition:
- Shared OFDM package holds:
  - state encoding localparams (IDLE, MUL, PREP, DIV, SAT);
  - the NDIV expression;
  - the saturation bounds as functions of SIZE_DATA.
- One natural sub-module: div_restoring_step, a combinational single restoring step (remainder, divisor -> next remainder, quotient bit), instantiated twice (I and Q).

Test Plan:
- a=16384,b=0,c=16384,d=0, en pulse -> after exactly 50 cycles: outputValid one cycle, out_i=16384, out_q=0, div_by_zero=0, busy low same cycle.
- a=16384,b=0,c=0,d=16384 (1/j) -> out_i=0, out_q=-16384.
- a=3,b=4,c=5,d=10 ((3+4j)/(5+10j)=0.44-0.08j) -> out_i=7208, out_q=-1310 (truncation toward zero).
- a=32767,b=-32768,c=1,d=0 -> out_i=32767, out_q=-32768 (saturation both rails); then c=d=0 -> out_i=out_q=0, div_by_zero=1, same 50-cycle latency.
- Back-to-back: en held high continuously for 3 operations -> exactly 3 outputValid pulses spaced 51 cycles apart; en pulses while busy produce no extra results.
- Reset: assert rst_n=0 at cycle 20 of an operation -> outputs/flags 0 immediately; no outputValid; a new en after release gives the correct result with latency 50.
